// File: rtl/fourdemux_16bit_buf_if.sv
// Bus bundle for the 1-to-4 buffered demultiplexer.
// Source side : In_Data, In_Select, In_Valid -> In_Ready
// Consumer side: A..D, Out_Valid -> Out_Ready
// Status      : Xfer_Count (accepted-word counter, wraps)
// modport slave  : the demultiplexer itself
// modport master : the source/consumer environment driving it
interface fourdemux_16bit_buf_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] In_Data;
  logic [1:0]       In_Select;
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic [3:0]       Out_Valid;
  logic [3:0]       Out_Ready;
  logic [CNT_W-1:0] Xfer_Count;

  modport slave (
    input  In_Data, In_Select, In_Valid, Out_Ready,
    output In_Ready, A, B, C, D, Out_Valid, Xfer_Count
  );

  modport master (
    output In_Data, In_Select, In_Valid, Out_Ready,
    input  In_Ready, A, B, C, D, Out_Valid, Xfer_Count
  );
endinterface

// File: rtl/fourdemux_16bit_buf.sv
// 1-to-4 demultiplexer with a one-word holding register per output channel
// and a valid/ready handshake on every output.
// Ports:
//   Clk      : clock, all state updates on the rising edge
//   Reset_n  : asynchronous active-low reset; clears flags, data, counter
//   bus      : fourdemux_16bit_buf_if.slave
//              In_Data/In_Select/In_Valid in, In_Ready out (combinational)
//              A..D + Out_Valid out, Out_Ready in (bit0=A .. bit3=D)
//              Xfer_Count out, number of accepted words (wraps)
module fourdemux_16bit_buf #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  fourdemux_16bit_buf_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_e;

  logic [3:0]       valid_w;
  logic [3:0]       load_w;
  logic [WIDTH-1:0] chan_data [4];
  logic             in_ready;
  logic [CNT_W-1:0] xfer_q;
  logic [CNT_W-1:0] xfer_d;

  // Ready only looks at the selected channel: it can take a word when it is
  // empty or when its consumer drains the current word in the same cycle.
  always_comb begin
    in_ready = ~valid_w[bus.In_Select] | bus.Out_Ready[bus.In_Select];
  end

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_chan
    chan_state_e      state_q;
    chan_state_e      state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             load;
    logic             drain;

    assign load  = bus.In_Valid & in_ready & (bus.In_Select == 2'(gi));
    assign drain = (state_q == FULL) & bus.Out_Ready[gi];

    always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
        EMPTY:   if (load) state_d = FULL;
        // A load in the same cycle as a drain refills the slot with no bubble.
        FULL:    if (drain & ~load) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
      // Data changes only on its own load; after a drain it stays as a
      // stale copy marked invalid by the flag.
      if (load) data_d = bus.In_Data;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        state_q <= EMPTY;
        data_q  <= '0;
      end else begin
        state_q <= state_d;
        data_q  <= data_d;
      end
    end

    assign load_w[gi]    = load;
    assign valid_w[gi]   = (state_q == FULL);
    assign chan_data[gi] = data_q;
  end

  // Exactly one channel matches In_Select, so any load is one accepted word.
  always_comb begin
    xfer_d = xfer_q;
    if (|load_w) xfer_d = xfer_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) xfer_q <= '0;
    else          xfer_q <= xfer_d;
  end

  assign bus.In_Ready   = in_ready;
  assign bus.A          = chan_data[0];
  assign bus.B          = chan_data[1];
  assign bus.C          = chan_data[2];
  assign bus.D          = chan_data[3];
  assign bus.Out_Valid  = valid_w;
  assign bus.Xfer_Count = xfer_q;

endmodule

// File: tb/tb_fourdemux_16bit_buf.sv
// Self-checking bench for fourdemux_16bit_buf: directed scenarios plus
// randomized traffic, compared every cycle against a behavioural model.
module tb_fourdemux_16bit_buf;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  fourdemux_16bit_buf_if #(.WIDTH(16), .CNT_W(16)) bus ();

  fourdemux_16bit_buf #(.WIDTH(16), .CNT_W(16)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: one slot per consumer plus a word counter.
  logic [15:0] md [4];
  bit          mv [4];
  logic [15:0] mcnt;

  int total = 0;
  int bad = 0;
  int txn = 0;
  bit quiet = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      md[i] = 16'h0;
      mv[i] = 1'b0;
    end
    mcnt = 16'h0;
  endfunction

  task automatic check_outputs();
    chk("out_valid", {28'h0, bus.Out_Valid}, {28'h0, mv[3], mv[2], mv[1], mv[0]});
    chk("A", {16'h0, bus.A}, {16'h0, md[0]});
    chk("B", {16'h0, bus.B}, {16'h0, md[1]});
    chk("C", {16'h0, bus.C}, {16'h0, md[2]});
    chk("D", {16'h0, bus.D}, {16'h0, md[3]});
    chk("xfer_count", {16'h0, bus.Xfer_Count}, {16'h0, mcnt});
  endtask

  // One clock cycle of traffic: drive, check ready, clock, update model, check.
  task automatic step(input logic [15:0] d, input logic [1:0] s,
                      input logic v, input logic [3:0] r);
    bit exp_rdy;
    bit acc;
    int sel;
    bus.In_Data   = d;
    bus.In_Select = s;
    bus.In_Valid  = v;
    bus.Out_Ready = r;
    #2;
    sel = int'(s);
    exp_rdy = !mv[sel] || r[sel];
    chk("in_ready", {31'h0, bus.In_Ready}, {31'h0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge Clk);
    for (int i = 0; i < 4; i++) begin
      if (acc && sel == i) begin
        md[i] = d;
        mv[i] = 1'b1;
      end else if (mv[i] && r[i]) begin
        mv[i] = 1'b0;
      end
    end
    if (acc) mcnt = mcnt + 16'd1;
    #1;
    check_outputs();
    txn++;
    if (!quiet)
      $display("txn %0d sel=%0d v=%0b rdy_in=%0b acc=%0b data=%h ovalid=%b cnt=%0d",
               txn, s, v, r, acc, d, bus.Out_Valid, bus.Xfer_Count);
  endtask

  task automatic idle(input logic [3:0] r);
    step(16'h0, 2'd0, 1'b0, r);
  endtask

  initial begin
    logic [15:0] route [4];
    route[0] = 16'h1111;
    route[1] = 16'h2222;
    route[2] = 16'h3333;
    route[3] = 16'h4444;

    bus.In_Data   = '0;
    bus.In_Select = '0;
    bus.In_Valid  = 1'b0;
    bus.Out_Ready = '0;
    model_reset();

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check_outputs();
    Reset_n = 1'b1;

    // Route one word to each channel, consumers stalled
    for (int i = 0; i < 4; i++) step(route[i], 2'(i), 1'b1, 4'b0000);

    // Drain C so it is empty for the backpressure switch
    idle(4'b0100);

    // Backpressure on A, then switch to empty C
    step(16'hAAAA, 2'd0, 1'b1, 4'b0000);
    step(16'hAAAB, 2'd0, 1'b1, 4'b0000);
    step(16'h5555, 2'd2, 1'b1, 4'b0000);

    // Stream 8 words to D with its consumer always ready
    for (int i = 0; i < 8; i++) step(16'hD000 + 16'(i), 2'd3, 1'b1, 4'b1000);
    idle(4'b1000);

    // Drain only B for one cycle
    idle(4'b0010);
    idle(4'b0000);

    // Async reset mid-stream with B full, no clock edge in between
    step(16'hBEEF, 2'd1, 1'b1, 4'b0000);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    for (int i = 0; i < 4; i++) begin
      bus.In_Select = 2'(i);
      bus.In_Valid  = 1'b1;
      #1;
      chk("in_ready_rst", {31'h0, bus.In_Ready}, 32'h1);
    end
    @(posedge Clk);
    #1;
    check_outputs();
    Reset_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(16'($urandom), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0), 4'($urandom));

    // Counter wrap: restart from zero, 65535 accepts, then one more
    @(negedge Clk);
    Reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    Reset_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 65535; i++)
      step(16'($urandom), 2'($urandom_range(0, 3)), 1'b1, 4'b1111);
    quiet = 1'b0;
    chk("count_ffff", {16'h0, bus.Xfer_Count}, 32'h0000FFFF);
    step(16'h1234, 2'd2, 1'b1, 4'b1111);
    chk("count_wrap", {16'h0, bus.Xfer_Count}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
